// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit.
//   state_t      : FSM states (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT)
//   OPC_*/F3_*/F7_* : opcode and function-field encodings of the supported subset
//   OPM_*        : OP_MEM_I codes presented to the address/ALU unit
//   ECALL_WORD   : the single instruction word that halts the machine
//   sext12       : sign-extends a 12-bit immediate to 64 bits
package uc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_DWORD  = 3'b011;

  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  localparam logic [1:0] OPM_ADDSUB = 2'd0;
  localparam logic [1:0] OPM_MEM    = 2'd1;
  localparam logic [1:0] OPM_ADDI   = 2'd2;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Bundle between the control unit, the instruction ROM and the datapath.
//   imem_addr/imem_data : instruction ROM address out, word back one cycle later
//   Ra/Rb/Rw            : register bank read A, read B and write addresses
//   WE_reg/WE_mem       : register bank and data memory write enables
//   OFFSET              : sign-extended immediate
//   OP_MEM_I/ADD_SUB    : address/ALU operation select
// master = control unit side, slave = ROM/datapath side.
interface unidade_controle_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [4:0]  Ra;
  logic [4:0]  Rb;
  logic [4:0]  Rw;
  logic        WE_reg;
  logic        WE_mem;
  logic [63:0] OFFSET;
  logic [1:0]  OP_MEM_I;
  logic        ADD_SUB;

  modport master (
    output imem_addr, Ra, Rb, Rw, WE_reg, WE_mem, OFFSET, OP_MEM_I, ADD_SUB,
    input  imem_data
  );

  modport slave (
    input  imem_addr, Ra, Rb, Rw, WE_reg, WE_mem, OFFSET, OP_MEM_I, ADD_SUB,
    output imem_data
  );
endinterface

// File: rtl/unidade_controle_decodificador.sv
// Combinational instruction decoder.
//   inst_i         : 32-bit instruction word
//   ra_o/rb_o/rw_o : register addresses for the datapath
//   offset_o       : sign-extended immediate (0 for add/sub)
//   op_mem_i_o     : operation select, add_sub_o : 1 = subtract
//   is_load_o/is_store_o/writes_reg_o : instruction class
//   is_halt_o      : ecall, is_illegal_o : any unsupported encoding
module decodificador
  import uc_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [4:0]  ra_o,
  output logic [4:0]  rb_o,
  output logic [4:0]  rw_o,
  output logic [63:0] offset_o,
  output logic [1:0]  op_mem_i_o,
  output logic        add_sub_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        writes_reg_o,
  output logic        is_halt_o,
  output logic        is_illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];

  always_comb begin
    ra_o         = '0;
    rb_o         = '0;
    rw_o         = '0;
    offset_o     = '0;
    op_mem_i_o   = OPM_ADDSUB;
    add_sub_o    = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    writes_reg_o = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;

    if (inst_i == ECALL_WORD) begin
      is_halt_o = 1'b1;
    end else if (opcode == OPC_OP && funct3 == F3_ADD &&
                 (funct7 == F7_ADD || funct7 == F7_SUB)) begin
      ra_o         = rs1;
      rb_o         = rs2;
      rw_o         = rd;
      add_sub_o    = (funct7 == F7_SUB);
      writes_reg_o = 1'b1;
    end else if (opcode == OPC_OPIMM && funct3 == F3_ADD) begin
      ra_o         = rs1;
      rw_o         = rd;
      offset_o     = sext12(inst_i[31:20]);
      op_mem_i_o   = OPM_ADDI;
      writes_reg_o = 1'b1;
    end else if (opcode == OPC_LOAD && funct3 == F3_DWORD) begin
      rb_o         = rs1;
      rw_o         = rd;
      offset_o     = sext12(inst_i[31:20]);
      op_mem_i_o   = OPM_MEM;
      is_load_o    = 1'b1;
      writes_reg_o = 1'b1;
    end else if (opcode == OPC_STORE && funct3 == F3_DWORD) begin
      // Store data comes out of port A, the base address out of port B.
      ra_o       = rs2;
      rb_o       = rs1;
      offset_o   = sext12({funct7, rd});
      op_mem_i_o = OPM_MEM;
      is_store_o = 1'b1;
    end else begin
      is_illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: owns PC, IR and halt/illegal status, fetches from a
// synchronous instruction ROM and sequences datapath controls per instruction.
//   clk, reset : clock and synchronous active-high reset
//   start      : one-cycle pulse that leaves IDLE
//   bus        : ROM address/data and datapath controls (master side)
//   busy       : running (not IDLE, not HALT)
//   halted     : in HALT; illegal : HALT was caused by an unsupported word
module unidade_controle
  import uc_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  unidade_controle_if.master bus,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [31:0] dec_inst;
  logic [4:0]  dec_ra, dec_rb, dec_rw;
  logic [63:0] dec_offset;
  logic [1:0]  dec_op_mem_i;
  logic        dec_add_sub, dec_is_load, dec_is_store;
  logic        dec_writes_reg, dec_is_halt, dec_is_illegal;
  logic        ctrl_active;

  // In DECODE the word arriving from the ROM is classified directly so the
  // halt/illegal branch is taken in the same cycle IR is loaded; afterwards
  // the decoder looks at IR.
  assign dec_inst = (state_q == S_DECODE) ? bus.imem_data : ir_q;

  decodificador u_dec (
    .inst_i       (dec_inst),
    .ra_o         (dec_ra),
    .rb_o         (dec_rb),
    .rw_o         (dec_rw),
    .offset_o     (dec_offset),
    .op_mem_i_o   (dec_op_mem_i),
    .add_sub_o    (dec_add_sub),
    .is_load_o    (dec_is_load),
    .is_store_o   (dec_is_store),
    .writes_reg_o (dec_writes_reg),
    .is_halt_o    (dec_is_halt),
    .is_illegal_o (dec_is_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d = bus.imem_data;
        if (dec_is_halt) begin
          state_d = S_HALT;
        end else if (dec_is_illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = dec_is_load ? S_MEM : S_WB;
      S_MEM:    state_d = S_WB;
      S_WB: begin
        pc_d    = pc_q + PC_STEP;
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control fields are only presented while an instruction is executing;
  // they are zero in IDLE/FETCH/DECODE/HALT.
  assign ctrl_active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  assign bus.imem_addr = pc_q;
  assign bus.Ra        = ctrl_active ? dec_ra       : 5'd0;
  assign bus.Rb        = ctrl_active ? dec_rb       : 5'd0;
  assign bus.Rw        = ctrl_active ? dec_rw       : 5'd0;
  assign bus.OFFSET    = ctrl_active ? dec_offset   : 64'd0;
  assign bus.OP_MEM_I  = ctrl_active ? dec_op_mem_i : OPM_ADDSUB;
  assign bus.ADD_SUB   = ctrl_active ? dec_add_sub  : 1'b0;

  // Reset gates the enables combinationally so a WB cycle caught by reset
  // never commits; x0 is never written.
  assign bus.WE_reg = (state_q == S_WB) && dec_writes_reg && (dec_rw != 5'd0) && !reset;
  assign bus.WE_mem = (state_q == S_WB) && dec_is_store && !reset;

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, halted, illegal;

  always #5 clk = ~clk;

  unidade_controle_if bus();

  unidade_controle #(.RESET_PC(64'h0), .PC_STEP(64'd4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus.master),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal)
  );

  // Synchronous instruction ROM: word valid the cycle after the address.
  logic [31:0] rom [0:63];
  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr[7:2]];

  typedef struct packed {
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        we_reg;
    logic        we_mem;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [63:0] off;
    logic [1:0]  opm;
    logic        addsub;
    logic [63:0] pc;
  } obs_t;

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LD = 3, K_SD = 4, K_ECALL = 5, K_ILL = 6;

  obs_t exp_q[$];
  obs_t obs [0:63];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   cyc = 0;

  function automatic obs_t sample();
    obs_t s;
    s.busy = busy; s.halted = halted; s.illegal = illegal;
    s.we_reg = bus.WE_reg; s.we_mem = bus.WE_mem;
    s.ra = bus.Ra; s.rb = bus.Rb; s.rw = bus.Rw;
    s.off = bus.OFFSET; s.opm = bus.OP_MEM_I; s.addsub = bus.ADD_SUB;
    s.pc = bus.imem_addr;
    return s;
  endfunction

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic int classify(input logic [31:0] w);
    if (w == 32'h0000_0073) return K_ECALL;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) return K_ADD;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20) return K_SUB;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return K_ADDI;
    if (w[6:0] == 7'h03 && w[14:12] == 3'd3) return K_LD;
    if (w[6:0] == 7'h23 && w[14:12] == 3'd3) return K_SD;
    return K_ILL;
  endfunction

  // Instruction-level model: walks the program from PC 0 and lists what the
  // outputs must be in each cycle after start (first entry = first FETCH).
  task automatic build_expect(input int n);
    logic [63:0] pc;
    bit          stop, ill;
    logic [31:0] w;
    int          k;
    obs_t        base, r;
    pc = 64'd0; stop = 1'b0; ill = 1'b0;
    exp_q.delete();
    while (exp_q.size() < n) begin
      if (stop) begin
        r = '0; r.halted = 1'b1; r.illegal = ill; r.pc = pc;
        exp_q.push_back(r);
      end else begin
        w = rom[pc[7:2]];
        k = classify(w);
        base = '0; base.busy = 1'b1; base.pc = pc;
        exp_q.push_back(base);   // FETCH
        exp_q.push_back(base);   // DECODE
        if (k == K_ECALL || k == K_ILL) begin
          stop = 1'b1;
          ill  = (k == K_ILL);
        end else begin
          r = base;
          case (k)
            K_ADD, K_SUB: begin
              r.ra = w[19:15]; r.rb = w[24:20]; r.rw = w[11:7];
              r.addsub = (k == K_SUB);
            end
            K_ADDI: begin
              r.ra = w[19:15]; r.rw = w[11:7];
              r.off = {{52{w[31]}}, w[31:20]}; r.opm = 2'd2;
            end
            K_LD: begin
              r.rb = w[19:15]; r.rw = w[11:7];
              r.off = {{52{w[31]}}, w[31:20]}; r.opm = 2'd1;
            end
            default: begin
              r.ra = w[24:20]; r.rb = w[19:15];
              r.off = {{52{w[31]}}, w[31:25], w[11:7]}; r.opm = 2'd1;
            end
          endcase
          exp_q.push_back(r);                    // EXEC
          if (k == K_LD) exp_q.push_back(r);     // MEM
          r.we_reg = (k != K_SD) && (w[11:7] != 5'd0);
          r.we_mem = (k == K_SD);
          exp_q.push_back(r);                    // WB
          pc = pc + 64'd4;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (chk_en) begin
      a = sample();
      cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL model_empty cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_%0d got %h want %h", cyc, a, e);
        end
      end
      if (cyc < 64) obs[cyc] = a;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", 160'(sample()), 160'(obs_t'('0)));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // FETCH begins at this edge
  endtask

  // Run n cycles under the compare process; stray start pulses while busy and
  // while halted must have no effect.
  task automatic run(input int n);
    pulse_start();
    cyc = 0;
    chk_en = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      #1 start = (c == 10 || c == 30);
    end
    start = 1'b0;
    chk_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;

    // Program 1: mixed instruction stream ending in ecall.
    rom[0] = 32'h0050_0093;   // addi x1,x0,5
    rom[1] = 32'h4020_81B3;   // sub  x3,x1,x2
    rom[2] = 32'hFE51_3C23;   // sd   x5,-8(x2)
    rom[3] = 32'hFF81_3303;   // ld   x6,-8(x2)
    rom[4] = 32'h0010_0013;   // addi x0,x0,1
    rom[5] = 32'h0094_03B3;   // add  x7,x8,x9
    rom[6] = 32'h0000_0073;   // ecall
    do_reset();
    build_expect(40);
    run(40);
    chk("addi_we",      160'(obs[4].we_reg), 160'(1));
    chk("addi_rw",      160'(obs[4].rw), 160'(1));
    chk("addi_off",     160'(obs[4].off), 160'(5));
    chk("addi_opm",     160'(obs[4].opm), 160'(2));
    chk("pc_after_1",   160'(obs[5].pc), 160'(4));
    chk("sub_exec",     160'({obs[7].ra, obs[7].rb, obs[7].rw, obs[7].addsub, obs[7].opm}),
                        160'({5'd1, 5'd2, 5'd3, 1'b1, 2'd0}));
    chk("sub_we_pulse", 160'({obs[7].we_reg, obs[8].we_reg, obs[9].we_reg}), 160'(3'b010));
    chk("sd_wb",        160'({obs[12].we_mem, obs[12].we_reg, obs[12].ra, obs[12].rb}),
                        160'({1'b1, 1'b0, 5'd5, 5'd2}));
    chk("sd_off",       160'(obs[12].off), 160'(64'hFFFF_FFFF_FFFF_FFF8));
    chk("ld_mem_no_we", 160'(obs[16].we_reg), 160'(0));
    chk("ld_wb",        160'({obs[17].we_reg, obs[17].rw}), 160'({1'b1, 5'd6}));
    chk("x0_no_we",     160'(obs[21].we_reg), 160'(0));
    chk("x0_pc_adv",    160'(obs[22].pc), 160'(20));
    chk("ecall_halt",   160'({obs[28].halted, obs[28].illegal, obs[28].busy}), 160'(3'b100));
    chk("ecall_pc",     160'(obs[28].pc), 160'(24));

    // Program 2: illegal word at address 0.
    rom[0] = 32'hFFFF_FFFF;
    do_reset();
    build_expect(8);
    run(8);
    chk("ill_halt",     160'({obs[3].halted, obs[3].illegal, obs[3].we_reg, obs[3].we_mem}), 160'(4'b1100));
    chk("ill_pc",       160'(obs[3].pc), 160'(0));

    // Program 3: reset lands in the WB cycle of an add.
    rom[0] = 32'h0050_0093;   // addi x1,x0,5
    rom[1] = 32'h0020_8233;   // add  x4,x1,x2
    do_reset();               // also shows the sticky illegal flag cleared
    pulse_start();
    repeat (8) @(negedge clk);
    chk("wb_before_rst", 160'({bus.WE_reg, bus.Rw, bus.imem_addr}), 160'({1'b1, 5'd4, 64'd4}));
    reset = 1'b1;
    #1;
    chk("wb_rst_we",     160'({bus.WE_reg, bus.WE_mem, busy}), 160'(3'b001));
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_idle",      160'({busy, halted, illegal}), 160'(0));
    chk("rst_pc",        160'(bus.imem_addr), 160'(0));
    @(negedge clk);
    chk("stay_idle",     160'({busy, bus.imem_addr}), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit sitting directly upstream of the processor datapath (register bank + address/ALU unit + data memory). It fetches 32-bit RV64-style instructions from a synchronous instruction ROM, decodes them, and sequences the datapath control signals (register addresses, write enables, immediate, operation select) over 4–5 cycles per instruction. It owns the PC, the instruction register, and the halt/illegal status.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- PC_STEP, 4, PC increment per retired instruction
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin execution from IDLE (single-cycle pulse)
- imem_addr  out  64  instruction address (= PC)
- imem_data  in  32  instruction word, valid the cycle after imem_addr is presented
- Ra  out  5  datapath read port A address
- Rb  out  5  datapath read port B address
- Rw  out  5  datapath write address
- WE_reg  out  1  register-bank write enable
- WE_mem  out  1  data-memory write enable
- OFFSET  out  64  sign-extended immediate
- OP_MEM_I  out  2  0 = add/sub, 1 = load/store, 2 = addi
- ADD_SUB  out  1  0 = add, 1 = subtract
- busy  out  1  1 in any state except IDLE and HALT
- halted  out  1  1 in HALT
- illegal  out  1  sticky; 1 if HALT was entered via an unsupported encoding

## Operation
- Supported: add/sub (opcode 0110011, funct3 000, funct7 0000000/0100000), addi (0010011, funct3 000), ld (0000011, funct3 011), sd (0100011, funct3 011), ecall 32'h00000073 = halt. Anything else is illegal.
- Field mapping: add/sub Ra=rs1, Rb=rs2, Rw=rd, OFFSET=0. addi Ra=rs1, Rw=rd, OFFSET=sext(inst[31:20]), OP_MEM_I=2, ADD_SUB=0. ld Rb=rs1, Rw=rd, OFFSET=sext(inst[31:20]), OP_MEM_I=1. sd Ra=rs2 (store data), Rb=rs1 (base), OFFSET=sext({inst[31:25],inst[11:7]}), OP_MEM_I=1.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE --start--> FETCH; start ignored in all other states.
- FETCH -> DECODE (imem_addr=PC held). DECODE: IR <= imem_data -> EXEC, or -> HALT if ecall/illegal (illegal set for illegal only; PC not advanced).
- EXEC: Ra/Rb/Rw/OFFSET/OP_MEM_I/ADD_SUB driven from IR, no enables. ld -> MEM; others -> WB.
- MEM (ld only): same controls held, no enables -> WB.
- WB: exactly one of WE_reg (add/sub/addi/ld) or WE_mem (sd) high for one cycle; PC <= PC + PC_STEP (64-bit wrap) -> FETCH.
- WE_reg suppressed when Rw = 0 (x0 never written).
- Control fields stay stable from EXEC through WB.
- HALT is absorbing; left only by reset.

## Timing
- Reset values: state IDLE, PC=RESET_PC, IR=0, Ra=Rb=Rw=0, OFFSET=0, OP_MEM_I=0, ADD_SUB=0, WE_reg=WE_mem=0, busy=halted=illegal=0.
- reset has priority over all transitions; while reset is high WE_reg and WE_mem are forced 0, so an instruction in WB during reset does not commit.
- Latency from start: first FETCH next cycle. add/sub/addi/sd: 4 cycles (FETCH, DECODE, EXEC, WB); ld: 5 cycles.
- imem_data sampled only in DECODE.

## Structure
- uc_pkg: state enum, opcode/funct constants, OP_MEM_I codes, ECALL word.
- Sub-module decodificador (combinational): IR -> Ra/Rb/Rw/OFFSET/OP_MEM_I/ADD_SUB, is_load, is_store, writes_reg, is_halt, is_illegal. FSM, PC and IR live in unidade_controle.

## Test plan
- reset then start, ROM[0]=addi x1,x0,5 -> WE_reg=1 with Rw=1, OFFSET=5, OP_MEM_I=2 in cycle 4; PC=4 after.
- sub x3,x1,x2 -> EXEC/WB Ra=1, Rb=2, Rw=3, ADD_SUB=1, OP_MEM_I=0; WE_reg 1 for exactly 1 cycle.
- sd x5,-8(x2) then ld x6,-8(x2) -> sd: Ra=5, Rb=2, OFFSET=64'hFFFF_FFFF_FFFF_FFF8, WE_mem=1 in cycle 4; ld: WE_reg=1 in cycle 5, Rw=6.
- addi x0,x0,1 -> WE_reg stays 0; PC advances by 4.
- word 32'hFFFFFFFF -> HALT after DECODE, illegal=1, halted=1, no enables, PC unchanged; ecall -> halted=1, illegal=0.
- reset asserted in the WB cycle of an add -> WE_reg=0 that cycle, next state IDLE, PC=RESET_PC.
